// File: rtl/gd_run_scheduler.sv
// gd_run_scheduler
// Run controller for the gradient-descent timer engine. Accepts a benchmark
// command (number of runs), repeatedly resets and starts the engine, and
// accumulates per-run statistics (total/min/max cycles, total FLOPs, runs
// completed). A per-run watchdog aborts a hung engine.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   cmd_valid/ready    command handshake, cmd_runs = number of runs (0..255)
//   eng_rst/eng_start  engine control (decoded from state)
//   eng_done/time/flops engine completion flag and per-run results
//   res_valid/ready    result handshake
//   res_*              result bundle, held stable while res_valid
//   busy               high in every state except IDLE
module gd_run_scheduler #(
    parameter int TIMEOUT = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_runs,
    output logic        eng_rst,
    output logic        eng_start,
    input  logic        eng_done,
    input  logic [31:0] eng_time,
    input  logic [31:0] eng_flops,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_runs_done,
    output logic [39:0] res_total_cycles,
    output logic [31:0] res_min_cycles,
    output logic [31:0] res_max_cycles,
    output logic [39:0] res_total_flops,
    output logic        res_timeout,
    output logic        busy
);

    // Wide enough to hold TIMEOUT itself, so the increment on the final
    // watchdog cycle never wraps.
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_CAP,
        S_RES
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  runs_q, runs_d;
    logic [39:0] tcyc_q, tcyc_d;
    logic [31:0] min_q, min_d;
    logic [31:0] max_q, max_d;
    logic [39:0] tflp_q, tflp_d;
    logic        to_q, to_d;
    logic [WW-1:0] wd_q, wd_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            runs_q   <= '0;
            tcyc_q   <= '0;
            min_q    <= '0;
            max_q    <= '0;
            tflp_q   <= '0;
            to_q     <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            runs_q   <= runs_d;
            tcyc_q   <= tcyc_d;
            min_q    <= min_d;
            max_q    <= max_d;
            tflp_q   <= tflp_d;
            to_q     <= to_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        runs_d   = runs_q;
        tcyc_d   = tcyc_q;
        min_d    = min_q;
        max_d    = max_q;
        tflp_d   = tflp_q;
        to_d     = to_q;
        wd_d     = wd_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    target_d = cmd_runs;
                    runs_d   = '0;
                    tcyc_d   = '0;
                    min_d    = '0;
                    max_d    = '0;
                    tflp_d   = '0;
                    to_d     = 1'b0;
                    wd_d     = '0;
                    state_d  = (cmd_runs == 8'd0) ? S_RES : S_CLR;
                end
            end
            S_CLR: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_q + 1'b1;
                // A done arriving on the final watchdog cycle still counts.
                if (eng_done) begin
                    state_d = S_CAP;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = S_RES;
                end
            end
            S_CAP: begin
                // Engine is out of reset here, so its outputs still hold the
                // values that accompanied done.
                tcyc_d = tcyc_q + {8'd0, eng_time};
                tflp_d = tflp_q + {8'd0, eng_flops};
                if (runs_q == 8'd0 || eng_time < min_q)
                    min_d = eng_time;
                if (eng_time > max_q)
                    max_d = eng_time;
                runs_d  = runs_q + 8'd1;
                state_d = (runs_d == target_q) ? S_RES : S_CLR;
            end
            S_RES: begin
                if (res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Everything below decodes registered state only.
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_RES);
    assign eng_start = (state_q == S_RUN);
    assign eng_rst   = (state_q == S_IDLE) || (state_q == S_CLR) ||
                       (state_q == S_RES);

    assign res_runs_done    = runs_q;
    assign res_total_cycles = tcyc_q;
    assign res_min_cycles   = min_q;
    assign res_max_cycles   = max_q;
    assign res_total_flops  = tflp_q;
    assign res_timeout      = to_q;

endmodule

// File: tb/tb_gd_run_scheduler.sv
// tb_gd_run_scheduler
// Self-checking bench for gd_run_scheduler. A behavioural engine model
// asserts done after a per-run latency (0 = never), and a reference model
// folds the per-run tables into the expected result bundle and latency.
module tb_gd_run_scheduler;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_runs = '0;
    logic        eng_rst, eng_start, eng_done;
    logic [31:0] eng_time, eng_flops;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_runs_done;
    logic [39:0] res_total_cycles, res_total_flops;
    logic [31:0] res_min_cycles, res_max_cycles;
    logic        res_timeout, busy;

    int n_chk = 0;
    int n_bad = 0;

    gd_run_scheduler #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_runs(cmd_runs),
        .eng_rst(eng_rst), .eng_start(eng_start), .eng_done(eng_done),
        .eng_time(eng_time), .eng_flops(eng_flops),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_runs_done(res_runs_done), .res_total_cycles(res_total_cycles),
        .res_min_cycles(res_min_cycles), .res_max_cycles(res_max_cycles),
        .res_total_flops(res_total_flops), .res_timeout(res_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- engine model ----------------
    int          lat [256];
    logic [31:0] tim [256];
    logic [31:0] flp [256];
    logic [31:0] ecnt = '0;
    logic [7:0]  ridx = '0;

    always @(posedge clk) begin
        if (eng_rst) ecnt <= '0;
        else if (eng_start) ecnt <= ecnt + 32'd1;
        if (!busy) ridx <= '0;
        else if (eng_done && !eng_start) ridx <= ridx + 8'd1;
    end

    assign eng_done  = !eng_rst && (lat[ridx] != 0) && (ecnt >= 32'(lat[ridx] - 1));
    assign eng_time  = tim[ridx];
    assign eng_flops = flp[ridx];

    // eng_rst must be high for exactly one cycle between RUN windows.
    int   rst_len = 0;
    bit   seen_run = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (!busy || !rst_n) begin
            seen_run = 0;
            rst_len  = 0;
        end else if (eng_start && !prev_start) begin
            if (seen_run) chk("rst_gap", 160'(rst_len), 160'(1));
            seen_run = 1;
            rst_len  = 0;
        end else if (eng_rst) begin
            rst_len++;
        end
        prev_start = eng_start;
    end

    // ---------------- reference model ----------------
    logic [7:0]  e_runs;
    logic [39:0] e_tot, e_tf;
    logic [31:0] e_mn, e_mx;
    logic        e_to;
    int          e_lat;

    task automatic model(input int r);
        logic [31:0] times [$];
        e_runs = 0; e_tot = 0; e_tf = 0; e_to = 0; e_lat = 1;
        for (int i = 0; i < r; i++) begin
            if (lat[i] == 0 || lat[i] > TO) begin
                e_to  = 1;
                e_lat += 1 + TO;
                break;
            end
            times.push_back(tim[i]);
            e_tot += 40'(tim[i]);
            e_tf  += 40'(flp[i]);
            e_lat += lat[i] + 2;
        end
        e_runs = 8'(times.size());
        e_mn = 0; e_mx = 0;
        if (times.size() > 0) begin
            times.sort();
            e_mn = times[0];
            e_mx = times[times.size() - 1];
        end
    endtask

    task automatic run_cmd(input string nm, input int r, input int hold);
        int cyc;
        model(r);
        @(negedge clk);
        chk({nm, ".cmd_ready"}, 160'(cmd_ready), 160'(1));
        cmd_valid = 1'b1;
        cmd_runs  = 8'(r);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < e_lat + 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, ".latency"}, 160'(cyc), 160'(e_lat));
        chk({nm, ".runs"},  160'(res_runs_done),    160'(e_runs));
        chk({nm, ".total"}, 160'(res_total_cycles), 160'(e_tot));
        chk({nm, ".min"},   160'(res_min_cycles),   160'(e_mn));
        chk({nm, ".max"},   160'(res_max_cycles),   160'(e_mx));
        chk({nm, ".flops"}, 160'(res_total_flops),  160'(e_tf));
        chk({nm, ".to"},    160'(res_timeout),      160'(e_to));
        chk({nm, ".eng"},   160'({eng_rst, eng_start, busy}), 160'(3'b101));
        // Backpressure: results held, new commands refused.
        for (int k = 0; k < hold; k++) begin
            cmd_valid = 1'b1;
            cmd_runs  = 8'($urandom);
            @(negedge clk);
            chk({nm, ".hold"},
                {7'd0, res_valid, cmd_ready, res_runs_done, res_total_cycles,
                 res_min_cycles, res_max_cycles, res_total_flops, res_timeout},
                {7'd0, 1'b1, 1'b0, e_runs, e_tot, e_mn, e_mx, e_tf, e_to});
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, ".drain"}, 160'({res_valid, cmd_ready, busy}), 160'(3'b010));
    endtask

    task automatic set_run(input int i, input int l, input logic [31:0] t, input logic [31:0] f);
        lat[i] = l; tim[i] = t; flp[i] = f;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) set_run(i, 2, 32'd0, 32'd0);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.outs", 160'({eng_rst, eng_start, res_valid, busy, cmd_ready}), 160'(5'b10001));
        chk("rst.res", 160'({res_runs_done, res_total_cycles, res_min_cycles,
                            res_max_cycles, res_total_flops, res_timeout}), 160'(0));
        rst_n = 1'b1;

        set_run(0, 20, 32'd19, 32'd95);
        run_cmd("single", 1, 0);

        set_run(0, 31, 32'd30, 32'd5);
        set_run(1, 11, 32'd10, 32'd5);
        set_run(2, 51, 32'd50, 32'd5);
        run_cmd("vary", 3, 2);

        for (int i = 0; i < 4; i++) set_run(i, 0, 32'd7, 32'd7);
        run_cmd("wdog", 4, 1);

        set_run(0, 41, 32'd40, 32'd3);
        set_run(1, 0, 32'd99, 32'd99);
        run_cmd("partial", 2, 0);

        run_cmd("zero", 0, 10);

        // done on the very last watchdog cycle still counts
        set_run(0, TO, 32'd123, 32'd4);
        set_run(1, TO - 1, 32'd122, 32'd4);
        run_cmd("edge", 2, 0);

        for (int i = 0; i < 255; i++) set_run(i, 2, $urandom, $urandom);
        run_cmd("full255", 255, 0);

        for (int t = 0; t < 15; t++) begin
            int r;
            r = $urandom_range(1, 6);
            for (int i = 0; i < r; i++)
                set_run(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, TO),
                        $urandom, $urandom);
            run_cmd("rand", r, $urandom_range(0, 3));
        end

        // reset in the middle of run 2
        for (int i = 0; i < 3; i++) set_run(i, 30, 32'd55, 32'd66);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_runs  = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        begin
            int w;
            w = 0;
            while (!(ridx == 8'd1 && eng_start) && w < 500) begin
                @(negedge clk);
                w++;
            end
            chk("midrst.reach", 160'(w < 500), 160'(1));
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.outs", 160'({eng_rst, eng_start, res_valid, busy, cmd_ready}), 160'(5'b10001));
        chk("midrst.res", 160'({res_runs_done, res_total_cycles, res_min_cycles,
                               res_max_cycles, res_total_flops, res_timeout}), 160'(0));
        rst_n = 1'b1;

        set_run(0, 5, 32'd8, 32'd9);
        run_cmd("after", 1, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/gd_run_scheduler.md
# gd_run_scheduler

Run controller for the gradient-descent timer engine. Accepts a benchmark command (number of runs), repeatedly resets and starts the engine, and collects each run's `time_elapsed` and `flops_count`. Produces aggregate statistics: total, min and max cycles, total FLOPs, and runs completed. A per-run watchdog aborts a hung engine. Sits between the host/UART command path and one engine instance.

## Interface

- `TIMEOUT`, 2048: watchdog limit, in cycles spent in RUN per run; must be ≥ 2.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `cmd_valid` in 1: benchmark command present.
- `cmd_ready` out 1: scheduler can accept a command (IDLE only).
- `cmd_runs` in 8: number of runs, 0..255.
- `eng_rst` out 1: active-high reset to the engine.
- `eng_start` out 1: level start to the engine.
- `eng_done` in 1: engine completion flag (level).
- `eng_time` in 32: engine `time_elapsed`.
- `eng_flops` in 32: engine `flops_count`.
- `res_valid` out 1: result bundle valid.
- `res_ready` in 1: consumer accepts the result.
- `res_runs_done` out 8: runs completed successfully.
- `res_total_cycles` out 40: sum of `eng_time` over completed runs.
- `res_min_cycles` out 32: minimum `eng_time`; 0 if no run completed.
- `res_max_cycles` out 32: maximum `eng_time`; 0 if no run completed.
- `res_total_flops` out 40: sum of `eng_flops`.
- `res_timeout` out 1: set when the command was aborted by the watchdog.
- `busy` out 1: high in every state except IDLE.

## Operation

- FSM states: IDLE, CLR, RUN, CAPTURE, RESULT. All outputs are registered or decoded from state only; no combinational path from input to output.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - `eng_rst` = 1, `eng_start` = 0.
  - `res_valid` = 0, `busy` = 0, `cmd_ready` = 1.
  - All result registers and counters are cleared to 0.
  - Reset mid-run abandons the run, and no result is produced.
- Output decode by state:
  - `eng_rst` = 1 in IDLE, CLR and RESULT; 0 in RUN and CAPTURE.
  - `eng_start` = 1 only in RUN.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid` the command is accepted. The scheduler latches `cmd_runs` as the target and clears the accumulators, `runs_done`, `res_timeout` and the watchdog.
  - If target = 0, go to RESULT directly; otherwise go to CLR.
- CLR: one cycle; clears the watchdog; then RUN.
- RUN:
  - The watchdog increments each cycle.
  - If `eng_done` = 1, go to CAPTURE. Done takes priority over the watchdog on the same cycle.
  - Otherwise, if watchdog = TIMEOUT−1: set `res_timeout`, go to RESULT, and leave the accumulators unchanged.
- CAPTURE (one cycle):
  - total_cycles += `eng_time`; total_flops += `eng_flops`. Both operands are zero-extended to 40 bits; no overflow is possible for ≤255 runs.
  - min = `eng_time` if `runs_done` = 0 or `eng_time` < min. max = `eng_time` if `eng_time` > max.
  - `runs_done` += 1.
  - If the new `runs_done` = target, go to RESULT; else go to CLR.
- RESULT:
  - `res_valid` = 1, and all `res_*` outputs are held stable.
  - On `res_ready` = 1, go to IDLE with `res_valid` = 0 the next cycle.
  - `cmd_valid` is ignored until IDLE is reached.

## Timing

- Command accepted at edge N: CLR at N+1, RUN at N+2 with `eng_start` = 1 and `eng_rst` = 0.
- `eng_done` sampled high at edge M: CAPTURE at M+1, then CLR or RESULT at M+2.
- Per-run overhead: 2 cycles (CLR, CAPTURE) plus the engine latency.
- Total latency from command accept to `res_valid` for R runs, each with engine latency Lᵢ (cycles in RUN): 1 + Σ(Lᵢ + 2).
- A command with 0 runs reaches RESULT one cycle after accept.
- The engine always sees at least one cycle of `eng_rst` between runs. A stale `eng_done` from the previous run therefore cannot be sampled in RUN.
- `res_valid`/`res_ready` follows a standard valid/ready handshake; a result is never dropped or duplicated.
- Timeout: RUN is entered at cycle N; with no done, RESULT is entered at N+TIMEOUT.

## Test plan

- **Single run:** bench engine model asserts done 20 cycles after start, with time=19 and flops=95; cmd_runs=1. Required: res_runs_done=1, total=19, min=max=19, total_flops=95, res_timeout=0. `res_valid` rises 1+(20+2) cycles after accept.
- **Varying latencies:** three runs with time 30, 10, 50 (flops 5 each). Required: runs_done=3, total=90, min=10, max=50, total_flops=15. `eng_rst` is high exactly 1 cycle between consecutive RUN windows.
- **Watchdog:** TIMEOUT=64, engine never asserts done, cmd_runs=4. Required: RESULT after 64 RUN cycles, res_timeout=1, runs_done=0, min=max=total=0, `eng_rst` reasserted.
- **Partial timeout:** the first run completes with time=40; the second hangs. Required: runs_done=1, total=40, res_timeout=1.
- **Zero runs and backpressure:** cmd_runs=0 with `res_ready` held low for 10 cycles. Required: `res_valid` one cycle after accept, outputs stable for all 10 cycles, and a second `cmd_valid` ignored until the handshake completes.
- **Reset mid-run:** `rst_n` driven low during RUN of run 2. Required next cycle: IDLE, `eng_rst`=1, `eng_start`=0, `res_valid`=0, all results 0, `cmd_ready`=1.
